// File: rtl/hippo_imem_loader_pkg.sv
// Shared state encoding and framing constants for the imem boot loader.
package hippo_imem_loader_Pkg;

   typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERROR} LoaderState;

   localparam int HdrBytes  = 4;
   localparam int WordBytes = 4;

endpackage

// File: rtl/hippo_byte_packer.sv
// Little-endian byte-to-word packer shared by the loader's header and payload phases.
module hippo_byte_packer
   import hippo_imem_loader_Pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  idx;
   logic [23:0] partial;

   // The completed word is presented combinationally on the 4th byte so the
   // consumer can register it on the same edge that accepts that byte.
   assign word       = {byte_data, partial};
   assign word_valid = byte_en && (idx == 2'(WordBytes - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         idx     <= 2'd0;
         partial <= 24'd0;
      end else if (byte_en) begin
         idx     <= idx + 2'd1;
         partial <= word[31:8];
      end
   end

endmodule

// File: rtl/hippo_imem_loader.sv
// Boot loader: packs a LE byte stream into imem words and holds the core in reset until done.
// Define HIPPO_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module hippo_imem_loader
   import hippo_imem_loader_Pkg::*;
#(
   parameter int AddrWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_data_i,
   output logic                 byte_ready_o,
   input  logic                 restart_i,
   output logic                 imem_we_o,
   output logic [AddrWidth-1:0] imem_addr_o,
   output logic [31:0]          imem_data_o,
   output logic                 core_rst_no,
   output logic                 done_o,
   output logic                 error_o,
   output logic [AddrWidth:0]   words_o
);

   localparam int Depth = 2 ** AddrWidth;
`ifdef HIPPO_LOADER_CHECKSUM_EN
   localparam LoaderState PayloadEnd = CSUM;
`else
   localparam LoaderState PayloadEnd = DONE;
`endif
   localparam bit EndsInDone = (PayloadEnd == DONE);

   LoaderState         state;
   logic [AddrWidth:0] n_words;
   logic [AddrWidth:0] words_next;
   logic               accept;
   logic               pack_en;
   logic               pack_clear;
   logic               word_valid;
   logic [31:0]        word;
`ifdef HIPPO_LOADER_CHECKSUM_EN
   logic [7:0]         csum;
`endif

   assign accept     = byte_valid_i && byte_ready_o;
   assign pack_en    = accept && (state == HDR || state == DATA);
   assign pack_clear = (state == DONE) || (state == ERROR);
   assign words_next = words_o + {{AddrWidth{1'b0}}, 1'b1};

   hippo_byte_packer u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (pack_clear),
      .byte_en    (pack_en),
      .byte_data  (byte_data_i),
      .word       (word),
      .word_valid (word_valid)
   );

   // Loader FSM. The header count is range-checked before any payload is accepted,
   // so the write address can never run past the end of imem.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= HDR;
         byte_ready_o <= 1'b0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_data_o  <= 32'd0;
         core_rst_no  <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         words_o      <= '0;
         n_words      <= '0;
`ifdef HIPPO_LOADER_CHECKSUM_EN
         csum         <= 8'd0;
`endif
      end else begin
         imem_we_o <= 1'b0;
         case (state)
            HDR: begin
               byte_ready_o <= 1'b1;
               if (word_valid) begin
                  if (word > 32'(Depth)) begin
                     state        <= ERROR;
                     byte_ready_o <= 1'b0;
                     error_o      <= 1'b1;
                  end else if (word == 32'd0) begin
                     state        <= PayloadEnd;
                     byte_ready_o <= !EndsInDone;
                     done_o       <= EndsInDone;
                     core_rst_no  <= EndsInDone;
                  end else begin
                     state   <= DATA;
                     n_words <= word[AddrWidth:0];
                  end
               end
            end
            DATA: begin
               if (word_valid) begin
                  imem_we_o   <= 1'b1;
                  imem_addr_o <= words_o[AddrWidth-1:0];
                  imem_data_o <= word;
                  words_o     <= words_next;
                  if (words_next == n_words) begin
                     state        <= PayloadEnd;
                     byte_ready_o <= !EndsInDone;
                     done_o       <= EndsInDone;
                     core_rst_no  <= EndsInDone;
                  end
               end
            end
`ifdef HIPPO_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  byte_ready_o <= 1'b0;
                  if (byte_data_i == csum) begin
                     state       <= DONE;
                     done_o      <= 1'b1;
                     core_rst_no <= 1'b1;
                  end else begin
                     state   <= ERROR;
                     error_o <= 1'b1;
                  end
               end
            end
`endif
            DONE, ERROR: begin
               if (restart_i) begin
                  state        <= HDR;
                  byte_ready_o <= 1'b1;
                  done_o       <= 1'b0;
                  error_o      <= 1'b0;
                  core_rst_no  <= 1'b0;
                  words_o      <= '0;
                  n_words      <= '0;
`ifdef HIPPO_LOADER_CHECKSUM_EN
                  csum         <= 8'd0;
`endif
               end
            end
            default: begin
               state        <= ERROR;
               byte_ready_o <= 1'b0;
               error_o      <= 1'b1;
               done_o       <= 1'b0;
               core_rst_no  <= 1'b0;
            end
         endcase
`ifdef HIPPO_LOADER_CHECKSUM_EN
         if (pack_en) begin
            csum <= csum ^ byte_data_i;
         end
`endif
      end
   end

endmodule

// File: tb/tb_hippo_imem_loader.sv
// Self-checking bench for hippo_imem_loader; checksum scenarios build only with
// HIPPO_LOADER_CHECKSUM_EN defined.
module tb_hippo_imem_loader;

   localparam int AddrWidth = 5;
   localparam int Depth     = 1 << AddrWidth;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 byte_valid_i;
   logic [7:0]           byte_data_i;
   logic                 byte_ready_o;
   logic                 restart_i;
   logic                 imem_we_o;
   logic [AddrWidth-1:0] imem_addr_o;
   logic [31:0]          imem_data_o;
   logic                 core_rst_no;
   logic                 done_o;
   logic                 error_o;
   logic [AddrWidth:0]   words_o;

   int checks   = 0;
   int failures = 0;

   logic [AddrWidth-1:0] wr_addr[$];
   logic [31:0]          wr_data[$];

   always #5 clk_i = ~clk_i;

   hippo_imem_loader #(.AddrWidth(AddrWidth)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .restart_i    (restart_i),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_data_o  (imem_data_o),
      .core_rst_no  (core_rst_no),
      .done_o       (done_o),
      .error_o      (error_o),
      .words_o      (words_o)
   );

   // Every imem write strobe is logged mid-cycle, away from the active edge.
   always @(negedge clk_i) begin
      if (imem_we_o) begin
         wr_addr.push_back(imem_addr_o);
         wr_data.push_back(imem_data_o);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: decode a complete frame into the words imem should receive.
   function automatic void model_frame(input logic [7:0] f[$], output logic [31:0] exp_w[$],
                                       output bit exp_done);
      logic [31:0] n;
      exp_w    = {};
      exp_done = 1'b0;
      n = {f[3], f[2], f[1], f[0]};
      if (n > Depth) return;
      for (int i = 0; i < int'(n); i++)
         exp_w.push_back({f[4*i+7], f[4*i+6], f[4*i+5], f[4*i+4]});
`ifdef HIPPO_LOADER_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'd0;
         for (int j = 0; j < 4 + 4 * int'(n); j++) x ^= f[j];
         exp_done = (f[4 + 4 * int'(n)] == x);
      end
`else
      exp_done = 1'b1;
`endif
   endfunction

   function automatic void build_frame(input logic [31:0] n, input logic [31:0] w[$],
                                       output logic [7:0] f[$]);
      f = {};
      for (int k = 0; k < 4; k++) f.push_back(n[8*k +: 8]);
      foreach (w[i]) for (int k = 0; k < 4; k++) f.push_back(w[i][8*k +: 8]);
`ifdef HIPPO_LOADER_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'd0;
         foreach (f[j]) x ^= f[j];
         f.push_back(x);
      end
`endif
   endfunction

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_byte(input logic [7:0] b);
      bit took;
      took         = 1'b0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      for (int budget = 0; budget < 40 && !took; budget++) begin
         took = byte_ready_o;
         @(negedge clk_i);
      end
      if (!took) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_byte: byte %02h never accepted, ready=%0b required 1", b, byte_ready_o);
      end
   endtask

   task automatic send_frame(input logic [7:0] f[$], input bit gaps, input bit random_gaps);
      foreach (f[i]) begin
         send_byte(f[i]);
         if (gaps && (!random_gaps || $urandom_range(0, 1) == 1)) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
            @(negedge clk_i);
         end
      end
      byte_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic do_restart();
      restart_i = 1'b1;
      @(negedge clk_i);
      restart_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'd0;
      restart_i    = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, core_rst_no, done_o, error_o, words_o} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values: ready=%0b we=%0b addr=%0d data=%08h crst_n=%0b done=%0b err=%0b words=%0d, required all 0",
                  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, core_rst_no, done_o, error_o, words_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (byte_ready_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ready_after_reset: got %0b required 1", byte_ready_o);
      end
   endtask

   task automatic test_basic_load();
      logic [7:0] f[$];
      f = {8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
`ifdef HIPPO_LOADER_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'd0;
         foreach (f[j]) x ^= f[j];
         f.push_back(x);
      end
`endif
      wr_addr.delete();
      wr_data.delete();
      send_frame(f, 1'b0, 1'b0);
      checks++;
      if (wr_data.size() !== 2) begin
         failures++;
         $display("[TB] FAIL basic_write_count: got %0d required 2", wr_data.size());
      end else begin
         checks++;
         if ({wr_addr[0], wr_data[0]} !== {5'd0, 32'h01020304}) begin
            failures++;
            $display("[TB] FAIL basic_word0: got %08h@%0d required 01020304@0", wr_data[0], wr_addr[0]);
         end
         checks++;
         if ({wr_addr[1], wr_data[1]} !== {5'd1, 32'h05060708}) begin
            failures++;
            $display("[TB] FAIL basic_word1: got %08h@%0d required 05060708@1", wr_data[1], wr_addr[1]);
         end
      end
      checks++;
      if ({done_o, core_rst_no, error_o, byte_ready_o} !== 4'b1100) begin
         failures++;
         $display("[TB] FAIL basic_status: done=%0b crst_n=%0b err=%0b ready=%0b required 1 1 0 0",
                  done_o, core_rst_no, error_o, byte_ready_o);
      end
      checks++;
      if (words_o !== 6'd2) begin
         failures++;
         $display("[TB] FAIL basic_words: got %0d required 2", words_o);
      end
      checks++;
      if ({imem_we_o, imem_data_o} !== {1'b0, 32'h05060708}) begin
         failures++;
         $display("[TB] FAIL basic_data_hold: we=%0b data=%08h required we=0 data=05060708", imem_we_o, imem_data_o);
      end
   endtask

   task automatic test_oversize();
      logic [7:0] f[$];
      do_restart();
      f = {8'(Depth + 1), 8'h00, 8'h00, 8'h00};
      wr_addr.delete();
      wr_data.delete();
      send_frame(f, 1'b0, 1'b0);
      checks++;
      if ({error_o, done_o, core_rst_no, byte_ready_o} !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL oversize_status: err=%0b done=%0b crst_n=%0b ready=%0b required 1 0 0 0",
                  error_o, done_o, core_rst_no, byte_ready_o);
      end
      checks++;
      if (wr_data.size() !== 0) begin
         failures++;
         $display("[TB] FAIL oversize_writes: got %0d strobes required 0", wr_data.size());
      end
      do_restart();
      checks++;
      if ({error_o, byte_ready_o, done_o, words_o} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
         failures++;
         $display("[TB] FAIL oversize_restart: err=%0b ready=%0b done=%0b words=%0d required 0 1 0 0",
                  error_o, byte_ready_o, done_o, words_o);
      end
   endtask

   task automatic test_valid_toggle();
      logic [7:0]  f[$];
      logic [31:0] w[$];
      w = {32'($urandom)};
      build_frame(32'd1, w, f);
      wr_addr.delete();
      wr_data.delete();
      send_frame(f, 1'b1, 1'b0);
      checks++;
      if (wr_data.size() !== 1) begin
         failures++;
         $display("[TB] FAIL toggle_write_count: got %0d required 1", wr_data.size());
      end else begin
         checks++;
         if ({wr_addr[0], wr_data[0]} !== {5'd0, w[0]}) begin
            failures++;
            $display("[TB] FAIL toggle_word: got %08h@%0d required %08h@0", wr_data[0], wr_addr[0], w[0]);
         end
      end
      checks++;
      if ({done_o, core_rst_no, words_o} !== {1'b1, 1'b1, 6'd1}) begin
         failures++;
         $display("[TB] FAIL toggle_status: done=%0b crst_n=%0b words=%0d required 1 1 1", done_o, core_rst_no, words_o);
      end
   endtask

   task automatic test_midload_reset();
      logic [7:0]  f[$];
      logic [31:0] w[$];
      do_restart();
      wr_addr.delete();
      wr_data.delete();
      f = {8'h03, 8'h00, 8'h00, 8'h00, 8'($urandom), 8'($urandom)};
      foreach (f[i]) send_byte(f[i]);
      byte_valid_i = 1'b0;
      rst_i        = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({words_o, core_rst_no, done_o, byte_ready_o, imem_we_o} !== {6'd0, 4'b0000}) begin
         failures++;
         $display("[TB] FAIL midreset_state: words=%0d crst_n=%0b done=%0b ready=%0b we=%0b required 0 0 0 0 0",
                  words_o, core_rst_no, done_o, byte_ready_o, imem_we_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (byte_ready_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_ready: got %0b required 1", byte_ready_o);
      end
      w = {32'($urandom)};
      build_frame(32'd1, w, f);
      send_frame(f, 1'b0, 1'b0);
      checks++;
      if (wr_data.size() !== 1 || wr_data[0] !== w[0] || wr_addr[0] !== 5'd0) begin
         failures++;
         $display("[TB] FAIL midreset_reload: %0d writes, first %08h, required 1 write of %08h@0",
                  wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0, w[0]);
      end
      checks++;
      if ({done_o, core_rst_no, words_o} !== {1'b1, 1'b1, 6'd1}) begin
         failures++;
         $display("[TB] FAIL midreset_status: done=%0b crst_n=%0b words=%0d required 1 1 1", done_o, core_rst_no, words_o);
      end
   endtask

   task automatic test_random_frames();
      logic [7:0]         f[$];
      logic [31:0]        w[$];
      logic [31:0]        exp_w[$];
      logic [31:0]        n;
      logic [AddrWidth:0] exp_words;
      bit                 exp_done;
      for (int iter = 0; iter < 10; iter++) begin
         do_restart();
         case (iter)
            0:       n = 32'd0;
            1:       n = 32'(Depth);
            2:       n = 32'(Depth + 1 + $urandom_range(0, 300));
            default: n = 32'($urandom_range(1, Depth));
         endcase
         if (n > Depth) begin
            f = {n[7:0], n[15:8], n[23:16], n[31:24]};
         end else begin
            w = {};
            for (int i = 0; i < int'(n); i++) w.push_back($urandom);
            build_frame(n, w, f);
`ifdef HIPPO_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) f[f.size()-1] ^= 8'($urandom_range(1, 255));
`endif
         end
         model_frame(f, exp_w, exp_done);
         exp_words = (AddrWidth+1)'(exp_w.size());
         wr_addr.delete();
         wr_data.delete();
         send_frame(f, 1'b1, 1'b1);
         checks++;
         if (wr_data.size() !== exp_w.size()) begin
            failures++;
            $display("[TB] FAIL rand_write_count iter %0d: got %0d required %0d", iter, wr_data.size(), exp_w.size());
         end
         for (int i = 0; i < exp_w.size() && i < wr_data.size(); i++) begin
            checks++;
            if ({wr_addr[i], wr_data[i]} !== {AddrWidth'(i), exp_w[i]}) begin
               failures++;
               $display("[TB] FAIL rand_word iter %0d idx %0d: got %08h@%0d required %08h@%0d",
                        iter, i, wr_data[i], wr_addr[i], exp_w[i], i);
            end
         end
         checks++;
         if ({done_o, error_o, core_rst_no, byte_ready_o} !== {exp_done, ~exp_done, exp_done, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rand_status iter %0d: done=%0b err=%0b crst_n=%0b ready=%0b required %0b %0b %0b 0",
                     iter, done_o, error_o, core_rst_no, byte_ready_o, exp_done, ~exp_done, exp_done);
         end
         checks++;
         if (words_o !== exp_words) begin
            failures++;
            $display("[TB] FAIL rand_words iter %0d: got %0d required %0d", iter, words_o, exp_words);
         end
      end
   endtask

`ifdef HIPPO_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] f[$];
      for (int pass = 0; pass < 2; pass++) begin
         do_restart();
         f = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, (pass == 0) ? 8'h01 : 8'h00};
         wr_addr.delete();
         wr_data.delete();
         send_frame(f, 1'b0, 1'b0);
         checks++;
         if (wr_data.size() !== 1 || wr_data[0] !== 32'hDDCCBBAA || wr_addr[0] !== 5'd0) begin
            failures++;
            $display("[TB] FAIL csum_write pass %0d: %0d writes, first %08h, required 1 write of DDCCBBAA@0",
                     pass, wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
         end
         checks++;
         if ({done_o, error_o, core_rst_no} !== ((pass == 0) ? 3'b101 : 3'b010)) begin
            failures++;
            $display("[TB] FAIL csum_status pass %0d: done=%0b err=%0b crst_n=%0b required %s",
                     pass, done_o, error_o, core_rst_no, (pass == 0) ? "1 0 1" : "0 1 0");
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_oversize();
      test_valid_toggle();
      test_midload_reset();
      test_random_frames();
`ifdef HIPPO_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
